// File: rtl/serial_select_pkg.sv
// Shared definitions for the serial select sequencer: FSM encoding and select-index limits.
// Optional SERIAL_SELECT_LOOP_EN build option lives in serial_select_sequencer.sv.
package serial_select_pkg;

  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] LAST_INDEX = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_select_sequencer_if.sv
// Handshake and mux-drive bundle between the sequencer and its controller.
// master = controller side, slave = sequencer side.
interface serial_select_sequencer_if;
  import serial_select_pkg::*;

  logic             load;
  logic             stop;
  logic [6:0]       data;
  logic [6:0]       mux_input;
  logic [SEL_W-1:0] mux_select;
  logic             busy;
  logic             done;

  modport master (
    output load, stop, data,
    input  mux_input, mux_select, busy, done
  );

  modport slave (
    input  load, stop, data,
    output mux_input, mux_select, busy, done
  );
endinterface

// File: rtl/rate_divider.sv
// Per-index dwell counter: counts 0..TICKS-1 and flags the last cycle of each index.
// Clear holds the count at zero so every index starts a fresh dwell.
module rate_divider #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST) && !clear;
endmodule

// File: rtl/serial_select_sequencer.sv
// Steps a 7-to-1 mux select through indices 0..6, TICKS cycles each, after a Load.
// Build option SERIAL_SELECT_LOOP_EN: wrap back to index 0 and keep scanning until Stop/Reset.
//
// state | meaning
// IDLE  | waiting for Load, select parked at 0
// SHIFT | scanning, Busy high
// DONE  | one-cycle Done pulse after a normal scan end
module serial_select_sequencer
  import serial_select_pkg::*;
#(
  parameter int TICKS = 4
) (
  input logic clk,
  input logic rst,
  serial_select_sequencer_if.slave bus
);
  state_t           state;
  logic [6:0]       mux_input;
  logic [SEL_W-1:0] mux_select;
  logic             busy;
  logic             done;
  logic             tick;
  logic             clear;

  // Hold the divider at zero outside SHIFT and on abort.
  assign clear = (state != SHIFT) || bus.stop;

  rate_divider #(.TICKS(TICKS)) u_rate_divider (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mux_input  <= '0;
      mux_select <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mux_select <= '0;
          if (bus.load) begin
            mux_input <= bus.data;
            state     <= SHIFT;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.stop) begin
            state      <= IDLE;
            mux_select <= '0;
            busy       <= 1'b0;
          end else if (tick) begin
            if (mux_select == LAST_INDEX) begin
`ifdef SERIAL_SELECT_LOOP_EN
              mux_select <= '0;
              done       <= 1'b1;
`else
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
              mux_select <= mux_select + 3'd1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          mux_select <= '0;
          busy       <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          mux_select <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_input  = mux_input;
  assign bus.mux_select = mux_select;
  assign bus.busy       = busy;
  assign bus.done       = done;
endmodule

// File: doc/serial_select_sequencer.md
SERIAL_SELECT_SEQUENCER -- requirements
Module: serial_select_sequencer

Interface
REQ-001 Parameter: TICKS, default 4, meaning clock cycles each select index is held; legal range 1..255.
REQ-002 Clock  input  1  system clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 Load  input  1  single-cycle request to capture Data and start a scan.
REQ-005 Stop  input  1  abort request; returns block to IDLE.
REQ-006 Data  input  7  pattern to be scanned, bit 0 first.
REQ-007 MuxInput  output  7  registered copy of Data; drives the 7-to-1 mux data inputs.
REQ-008 MuxSelect  output  3  registered select index 0..6; drives the 7-to-1 mux select.
REQ-009 Busy  output  1  high while a scan is in progress (SHIFT state).
REQ-010 Done  output  1  one-cycle pulse when a scan completes normally.

Function
REQ-011 FSM states SHIFT, DONE, IDLE; all outputs registered, no combinational input-to-output path.
REQ-012 IDLE: Busy=0, Done=0, MuxSelect=0, MuxInput holds last captured value; Stop has no effect.
REQ-013 IDLE with Load=1 at edge k: MuxInput<=Data, MuxSelect<=0, tick counter<=0, state<=SHIFT; Busy=1 from cycle after edge k.
REQ-014 SHIFT: tick counter increments each cycle; when it reaches TICKS-1 it clears and MuxSelect increments by 1.
REQ-015 Each index 0..6 held exactly TICKS cycles; full scan = 7*TICKS Busy cycles.
REQ-016 SHIFT with MuxSelect=6 and counter=TICKS-1: state<=DONE, MuxSelect held at 6.
REQ-017 DONE lasts exactly one cycle: Done=1, Busy=0; then IDLE with MuxSelect<=0.
REQ-018 Load while in SHIFT or DONE is ignored; Data is not recaptured.
REQ-019 Stop in SHIFT or DONE: next state IDLE, MuxSelect<=0, counter<=0, no Done pulse; Stop beats Load and end-of-scan in the same cycle.
REQ-020 MuxSelect never takes values 7; counter width = ceil(log2(TICKS)), minimum 1 bit.
REQ-021 TICKS=1: MuxSelect advances every cycle.

Reset
REQ-022 Reset=1 at an edge: state<=IDLE, MuxInput<=0, MuxSelect<=0, counter<=0, Busy<=0, Done<=0.
REQ-023 Reset overrides Load and Stop in the same cycle; reset mid-scan aborts without Done.

Configuration
REQ-024 Macro SERIAL_SELECT_LOOP_EN: when defined, end of index 6 wraps MuxSelect to 0 and remains in SHIFT, Done pulses once per wrap, scan ends only via Stop or Reset.
REQ-025 Without SERIAL_SELECT_LOOP_EN: single scan per Load as in REQ-016/017.

Structure
REQ-026 Shared package serial_select_pkg holds the state encoding (IDLE, SHIFT, DONE), constant LAST_INDEX=6 and select width 3.
REQ-027 Sub-module rate_divider (parameter TICKS, Clock, Reset, Clear, Tick pulse output) implements the per-index tick counter.
REQ-028 Intended top-level hookup: MuxInput and MuxSelect feed the existing 7-to-1 mux; mux output is the serial bit stream.

Verification (TICKS=2 unless noted)
REQ-029 Reset then idle 5 cycles -> all outputs 0, MuxSelect=0.
REQ-030 Data=7'b1010011, Load 1 cycle -> MuxInput=7'b1010011, MuxSelect sequence 0,0,1,1,...,6,6, Busy high 14 cycles, Done pulse cycle 15, then MuxSelect=0.
REQ-031 Load with Data=7'h7F during SHIFT of Data=7'h01 -> MuxInput stays 7'h01, scan timing unchanged.
REQ-032 Stop at MuxSelect=3 -> next cycle IDLE, Busy=0, MuxSelect=0, no Done; same with Load asserted simultaneously.
REQ-033 Reset asserted at MuxSelect=5 -> next cycle all outputs 0, no Done.
REQ-034 TICKS=1 with SERIAL_SELECT_LOOP_EN defined -> MuxSelect 0..6,0..6 per cycle, Done every 7 cycles until Stop.
